// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: opcodes, FSM states, helpers.
package rv32m_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    function automatic logic is_signed_div(input logic [2:0] op);
        return op[2] && !op[0];
    endfunction

endpackage

// File: rtl/rv32m_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, 32 cycles after load.
module rv32m_divider
    import rv32m_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quo_next,
    output logic [DATA_W-1:0] rem_next,
    output logic              last
);

    logic [DATA_W-1:0] quo_p0;
    logic [DATA_W-1:0] rem_p0;
    logic [DATA_W-1:0] dsr_p0;
    logic [4:0]        cnt_p0;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // Partial remainder stays below the divisor, so bit DATA_W of diff is its sign.
    always_comb begin
        shifted  = {rem_p0, quo_p0[DATA_W-1]};
        diff     = shifted - {1'b0, dsr_p0};
        rem_next = shifted[DATA_W-1:0];
        quo_next = {quo_p0[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W]) begin
            rem_next = diff[DATA_W-1:0];
            quo_next = {quo_p0[DATA_W-2:0], 1'b1};
        end
    end

    assign last = (cnt_p0 == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= 5'd0;
        end else if (load) begin
            cnt_p0 <= 5'd0;
        end else begin
            cnt_p0 <= cnt_p0 + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            quo_p0 <= dividend;
            rem_p0 <= '0;
            dsr_p0 <= divisor;
        end else begin
            quo_p0 <= quo_next;
            rem_p0 <= rem_next;
        end
    end

endmodule

// File: rtl/rv32m_unit.sv
// RV32M execution unit: single-cycle multiply, iterative divide, registered result
// with a one-cycle READY pulse per completed operation.
module rv32m_unit
    import rv32m_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [2:0]        M_CNT,
    input  logic [DATA_W-1:0] RS1,
    input  logic [DATA_W-1:0] RS2,
    output logic [DATA_W-1:0] OUT,
    output logic              READY
);

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Divide-by-zero and signed overflow bypass the iterative divider.
    function automatic logic is_special(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
        return op[2] && ((b == '0) ||
               (is_signed_div(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [DATA_W-1:0] special_result(input logic [2:0] op,
                                                         input logic [DATA_W-1:0] a,
                                                         input logic [DATA_W-1:0] b);
        if (b == '0) return op[1] ? a : '1;
        return op[1] ? '0 : 32'h8000_0000;
    endfunction

    state_t            state;
    logic [2:0]        op_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;

    logic signed [DATA_W:0]     mul_a;
    logic signed [DATA_W:0]     mul_b;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          mul_res;
    logic [DATA_W-1:0]          div_res;

    logic              div_load;
    logic              in_sgn;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dsr_mag;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] rem_next;
    logic              div_last;

    // Stage p0: operand capture while idle; the START edge holds the final copy.
    always_ff @(posedge CLK) begin
        if (state == ST_IDLE) begin
            op_p0 <= M_CNT;
            a_p0  <= RS1;
            b_p0  <= RS2;
        end
    end

    assign in_sgn   = is_signed_div(M_CNT);
    assign dvd_mag  = cond_neg(RS1, in_sgn && RS1[DATA_W-1]);
    assign dsr_mag  = cond_neg(RS2, in_sgn && RS2[DATA_W-1]);
    assign div_load = (state == ST_IDLE);

    rv32m_divider u_div (
        .clk      (CLK),
        .rst      (RST),
        .load     (div_load),
        .dividend (dvd_mag),
        .divisor  (dsr_mag),
        .quo_next (quo_next),
        .rem_next (rem_next),
        .last     (div_last)
    );

    always_comb begin
        mul_a   = $signed({(op_p0 == OP_MULH || op_p0 == OP_MULHSU) && a_p0[DATA_W-1], a_p0});
        mul_b   = $signed({(op_p0 == OP_MULH) && b_p0[DATA_W-1], b_p0});
        prod    = mul_a * mul_b;
        mul_res = (op_p0 == OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
        if (op_p0[2]) mul_res = special_result(op_p0, a_p0, b_p0);
        div_res = op_p0[1]
                ? cond_neg(rem_next, is_signed_div(op_p0) && a_p0[DATA_W-1])
                : cond_neg(quo_next, is_signed_div(op_p0) && (a_p0[DATA_W-1] ^ b_p0[DATA_W-1]));
    end

    // Stage p1: control FSM and registered result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            OUT   <= '0;
            READY <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    READY <= 1'b0;
                    if (START) begin
                        state <= (!M_CNT[2] || is_special(M_CNT, RS1, RS2)) ? ST_MUL : ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (!START) begin
                        state <= ST_IDLE;
                    end else begin
                        OUT   <= mul_res;
                        READY <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (!START) begin
                        state <= ST_IDLE;
                    end else if (div_last) begin
                        OUT   <= div_res;
                        READY <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    READY <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_unit.sv
// Bench for rv32m_unit: directed RV32M cases plus random ops against an arithmetic model.
module tb_rv32m_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [2:0]  M_CNT;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic [31:0] OUT;
    logic        READY;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_out;

    always #5 CLK = ~CLK;

    rv32m_unit dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .M_CNT (M_CNT),
        .RS1   (RS1),
        .RS2   (RS2),
        .OUT   (OUT),
        .READY (READY)
    );

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          ia;
        int          ib;
        logic        ovf;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(b); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op < 3'd4 || b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns one edge after READY has dropped again.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int          n;
        logic [31:0] exp;
        exp   = ref_res(op, a, b);
        M_CNT = op;
        RS1   = a;
        RS2   = b;
        START = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge CLK);
            #1;
            n++;
            if (READY) break;
            RS1   = $urandom;
            RS2   = $urandom;
            M_CNT = 3'($urandom_range(0, 7));
        end
        check({tag, " latency"}, n, ref_lat(op, a, b));
        check({tag, " result"}, OUT, exp);
        last_out = exp;
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, " ready drop"}, {31'b0, READY}, 32'd0);
    endtask

    initial begin
        int          n;
        logic        saw;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        RST   = 1'b1;
        START = 1'b0;
        M_CNT = 3'd0;
        RS1   = '0;
        RS2   = '0;
        last_out = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset OUT", OUT, 32'd0);
        check("reset READY", {31'b0, READY}, 32'd0);

        @(negedge CLK); RST = 1'b0;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3");
        @(negedge CLK); do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
        @(negedge CLK); do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        @(negedge CLK); do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        @(negedge CLK); do_op(3'd4, 32'hFFFF_FFEC, 32'd6, "div -20/6");
        @(negedge CLK); do_op(3'd6, 32'hFFFF_FFEC, 32'd6, "rem -20/6");
        @(negedge CLK); do_op(3'd5, 32'd100, 32'd7, "divu 100/7");
        @(negedge CLK); do_op(3'd7, 32'd100, 32'd7, "remu 100/7");
        @(negedge CLK); do_op(3'd5, 32'd5, 32'd0, "divu by 0");
        @(negedge CLK); do_op(3'd7, 32'd5, 32'd0, "remu by 0");
        @(negedge CLK); do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        @(negedge CLK); do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");

        // Back-to-back: START held through DONE into the next IDLE.
        @(negedge CLK);
        M_CNT = 3'd0; RS1 = 32'd3; RS2 = 32'd5; START = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge CLK); #1; n++;
            if (READY) break;
        end
        check("b2b mul latency", n, 32'd2);
        check("b2b mul result", OUT, 32'd15);
        @(negedge CLK);
        M_CNT = 3'd5; RS1 = 32'd100; RS2 = 32'd7;
        @(posedge CLK); #1;
        check("b2b gap", {31'b0, READY}, 32'd0);
        n = 0;
        while (n < 40) begin
            @(posedge CLK); #1; n++;
            if (READY) break;
        end
        check("b2b divu latency", n, 32'd33);
        check("b2b divu result", OUT, 32'd14);
        last_out = 32'd14;
        @(negedge CLK); START = 1'b0;
        @(posedge CLK); #1;

        // Abort: START dropped mid-divide.
        @(negedge CLK);
        M_CNT = 3'd4; RS1 = 32'hFFFF_FFEC; RS2 = 32'd6; START = 1'b1;
        repeat (10) @(posedge CLK);
        @(negedge CLK); START = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (READY) saw = 1'b1;
        end
        check("abort no READY", {31'b0, saw}, 32'd0);
        check("abort OUT hold", OUT, last_out);

        // Reset mid-divide, then start in the first idle cycle after release.
        @(negedge CLK);
        M_CNT = 3'd5; RS1 = 32'd1000; RS2 = 32'd3; START = 1'b1;
        repeat (10) @(posedge CLK);
        @(negedge CLK); RST = 1'b1; START = 1'b0;
        @(posedge CLK); #1;
        check("midrst OUT", OUT, 32'd0);
        check("midrst READY", {31'b0, READY}, 32'd0);
        @(negedge CLK); RST = 1'b0;
        do_op(3'd5, 32'd1000, 32'd3, "post-reset divu");

        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 15);
                4: b = -($urandom_range(1, 15));
                default: ;
            endcase
            @(negedge CLK);
            do_op(op, a, b, $sformatf("rnd%0d op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32m_unit.md
RV32M_UNIT -- requirements
Module: rv32m_unit

Interface
REQ-001 SHALL expose CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL expose RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose START  input  1  level request; held high by the pipeline while it stalls on READY=0.
REQ-004 SHALL expose M_CNT  input  3  operation select, RV32M funct3 encoding.
REQ-005 SHALL expose RS1  input  32  rs1 operand (multiplicand / dividend).
REQ-006 SHALL expose RS2  input  32  rs2 operand (multiplier / divisor).
REQ-007 SHALL expose OUT  output  32  result; valid whenever READY=1.
REQ-008 SHALL expose READY  output  1  result-valid / completion flag.

Function
REQ-009 SHALL decode M_CNT: 000 MUL low 32; 001 MULH s*s high; 010 MULHSU RS1 signed * RS2 unsigned high; 011 MULHU u*u high; 100 DIV; 101 DIVU; 110 REM; 111 REMU.
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-011 IDLE & START: SHALL capture RS1, RS2, M_CNT at that edge; go MUL for 0xx or special-case divide, else DIV.
REQ-012 MUL SHALL compute the full 64-bit product (operands sign/zero-extended per op) in one cycle, register the selected half, go DONE.
REQ-013 DIV SHALL run 32 restoring shift-subtract iterations on magnitudes (abs for signed ops), one bit per cycle, then go DONE.
REQ-014 Signed divide SHALL negate quotient when operand signs differ; remainder takes dividend sign.
REQ-015 Divisor zero SHALL resolve via MUL-path latency: quotient 0xFFFFFFFF (DIV and DIVU), remainder = dividend.
REQ-016 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL resolve via MUL-path latency: DIV 0x80000000, REM 0.
REQ-017 READY SHALL be 1 exactly while state=DONE, 0 otherwise; it SHALL be 0 in IDLE even with START high.
REQ-018 DONE SHALL last one cycle then return to IDLE; START still high in the following IDLE cycle starts a new operation (back-to-back ops).
REQ-019 Latency SHALL be: READY high in the cycle after 2 edges (MUL/special) or 33 edges (DIV) counted from the edge sampling START in IDLE.
REQ-020 START deasserting in MUL or DIV SHALL abort to IDLE with no DONE; OUT unchanged.
REQ-021 OUT SHALL be registered and hold the last completed result until the next completion.
REQ-022 Operand changes on RS1/RS2/M_CNT after capture SHALL not affect the in-flight result.

Reset
REQ-023 RST=1 at an edge SHALL force state IDLE, OUT=0, READY=0, iteration counter 0, overriding START and any in-flight operation.
REQ-024 First START accepted SHALL be in the first IDLE cycle after RST falls.

Structure
REQ-025 Shared package SHALL hold M_CNT opcode constants (MUL..REMU) and the FSM state enum.
REQ-026 The iterative divider (magnitude dividend/divisor in, quotient/remainder out, 32-cycle counter) SHALL be sub-module rv32m_divider; multiply and sign handling stay in rv32m_unit.

Verification
REQ-027 MUL: RS1=7, RS2=-3 (0xFFFFFFFD), M_CNT=000, START held -> READY after 2 edges, OUT=0xFFFFFFEB.
REQ-028 MULH/MULHSU/MULHU with RS1=0xFFFFFFFF, RS2=0xFFFFFFFF -> OUT 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
REQ-029 DIV RS1=-20, RS2=6 -> after 33 edges OUT=0xFFFFFFFD; REM same operands -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU -> 2.
REQ-030 Divide by zero DIVU 5/0 -> 0xFFFFFFFF, REMU -> 5; overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; both after 2 edges.
REQ-031 Back-to-back: START held across two ops (MUL then DIVU) -> READY pulses once per op, one low cycle between, each OUT correct.
REQ-032 Abort/reset: drop START at DIV cycle 10 -> no READY, OUT unchanged; assert RST mid-DIV -> OUT=0, READY=0, next START completes normally.
